// File: rtl/decode_ctrl.sv
// decode_ctrl: RV32I decode stage -- IF/ID and ID/EX registers, immediate and control decode,
// load-use stall sequencing and branch/jump flushes. Define UTYPE_EN to decode LUI/AUIPC.
module decode_ctrl #(
    parameter int XLEN            = 32,
    parameter int LOAD_USE_STALLS = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] InstrF,
    input  logic [XLEN-1:0] PCF,
    input  logic            ValidF,
    input  logic            FlushD,
    input  logic            FlushE,
    input  logic            HoldAll,
    output logic            StallF,
    output logic [2:0]      ImmSrcD,
    output logic            ValidE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            ALUSrcE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [1:0]      ResultSrcE,
    output logic            IllegalE
);
    typedef enum logic {RUN, STALL} state_t;

    // The hazard cycle itself is the first bubble, so STALL only covers the remaining ones.
    localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_STALLS - 1);
    localparam state_t     HAZ_NEXT = (LOAD_USE_STALLS > 1) ? STALL : RUN;

    state_t          state;
    logic [1:0]      cnt;
    logic            valid_d;
    logic [XLEN-1:0] instr_d;
    logic [XLEN-1:0] pc_d;
    logic [2:0]      imm_src;
    logic [XLEN-1:0] imm_ext;
    logic            illegal;
    logic            reg_write;
    logic            mem_write;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic [1:0]      result_src;
    logic            use_rs1;
    logic            use_rs2;
    logic            hazard;
    logic            stall;
    logic            bubble;

    // Opcode decode into immediate format, EX controls and source-register usage.
    always_comb begin
        imm_src    = 3'b000;
        illegal    = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        result_src = 2'b00;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        case (instr_d[6:0])
            7'b0000011: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = 2'b01;
                use_rs1    = 1'b1;
            end
            7'b0010011: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                use_rs1   = 1'b1;
            end
            7'b1100111: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                jump       = 1'b1;
                result_src = 2'b10;
                use_rs1    = 1'b1;
            end
            7'b0110011: begin
                reg_write = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            7'b0100011: begin
                imm_src   = 3'b001;
                mem_write = 1'b1;
                alu_src   = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            7'b1100011: begin
                imm_src = 3'b010;
                branch  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b1101111: begin
                imm_src    = 3'b011;
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = 2'b10;
            end
`ifdef UTYPE_EN
            7'b0110111, 7'b0010111: begin
                imm_src   = 3'b100;
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

    // Sign-extended immediate in the decoded format; R-type and illegal fall back to I-form.
    always_comb begin
        case (imm_src)
            3'b001:  imm_ext = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            3'b010:  imm_ext = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
            3'b011:  imm_ext = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
`ifdef UTYPE_EN
            3'b100:  imm_ext = {instr_d[31:12], 12'b0};
`endif
            default: imm_ext = {{20{instr_d[31]}}, instr_d[31:20]};
        endcase
    end

    assign ImmSrcD = imm_src;
    assign hazard  = ValidE && ResultSrcE == 2'b01 && RdE != 5'd0 && valid_d &&
                     ((use_rs1 && RdE == instr_d[19:15]) || (use_rs2 && RdE == instr_d[24:20]));
    assign stall   = state == STALL || hazard;
    assign bubble  = FlushE || stall || !valid_d;
    assign StallF  = HoldAll || stall;

    // Stall sequencer: a flush kills the dependent instruction, so it cancels any pending bubbles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else if (!HoldAll) begin
            if (FlushE) begin
                state <= RUN;
                cnt   <= 2'd0;
            end else if (state == STALL) begin
                state <= (cnt > 2'd1) ? STALL : RUN;
                cnt   <= cnt - 2'd1;
            end else if (hazard) begin
                state <= HAZ_NEXT;
                cnt   <= CNT_INIT;
            end
        end
    end

    // IF/ID register: flush beats stall; the held NOP keeps ImmSrcD benign after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_d <= 1'b0;
            instr_d <= 32'h0000_0013;
            pc_d    <= '0;
        end else if (!HoldAll) begin
            if (FlushD) begin
                valid_d <= 1'b0;
            end else if (!stall) begin
                valid_d <= ValidF;
                instr_d <= InstrF;
                pc_d    <= PCF;
            end
        end
    end

    // ID/EX register: bubbles carry all-zero fields so nothing downstream acts on them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ValidE     <= 1'b0;
            PCE        <= '0;
            ImmExtE    <= '0;
            Rs1E       <= 5'd0;
            Rs2E       <= 5'd0;
            RdE        <= 5'd0;
            RegWriteE  <= 1'b0;
            MemWriteE  <= 1'b0;
            ALUSrcE    <= 1'b0;
            BranchE    <= 1'b0;
            JumpE      <= 1'b0;
            ResultSrcE <= 2'b00;
            IllegalE   <= 1'b0;
        end else if (!HoldAll) begin
            ValidE     <= !bubble;
            PCE        <= bubble ? '0 : pc_d;
            ImmExtE    <= bubble ? '0 : imm_ext;
            Rs1E       <= bubble ? 5'd0 : instr_d[19:15];
            Rs2E       <= bubble ? 5'd0 : instr_d[24:20];
            RdE        <= bubble ? 5'd0 : instr_d[11:7];
            RegWriteE  <= !bubble && reg_write;
            MemWriteE  <= !bubble && mem_write;
            ALUSrcE    <= !bubble && alu_src;
            BranchE    <= !bubble && branch;
            JumpE      <= !bubble && jump;
            ResultSrcE <= bubble ? 2'b00 : result_src;
            IllegalE   <= !bubble && illegal;
        end
    end
endmodule
